// File: rtl/jt10_adpcm_romarb.sv
// Shares one sample-ROM read port between the ADPCM-A and ADPCM-B engines.
// Each engine has a one-deep request slot. Grants go round-robin, and the tag of the last fetch suppresses repeat reads.
module jt10_adpcm_romarb #(
   parameter int AW = 24
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_roe_n,
   input  logic [AW-1:0] a_addr,
   output logic [7:0]    a_data,
   input  logic          b_roe_n,
   input  logic [AW-1:0] b_addr,
   output logic [7:0]    b_data,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [7:0]    mem_din,
   output logic          busy,
   output logic          ovr_a,
   output logic          ovr_b,
   input  logic          ovr_clr
);

   typedef enum logic {S_IDLE, S_REQ} state_t;

   state_t          state_reg;
   logic            mem_req_reg;
   logic [AW-1:0]   mem_addr_reg;
   logic            busy_reg;
   logic            last_grant_reg;   // 0 = A, 1 = B

   logic [1:0]         roe;
   logic [1:0][AW-1:0] addr_in;
   logic [1:0]         pend_vec;
   logic [1:0][AW-1:0] paddr_vec;
   logic [1:0][7:0]    data_vec;
   logic [1:0]         ovr_vec;
   logic [1:0]         grant;
   logic [1:0]         ack_sel;
   logic               grant_en;
   logic               grant_sel;

   assign roe     = {~b_roe_n, ~a_roe_n};
   assign addr_in = {b_addr, a_addr};

   // When both requesters are pending, the one not served last wins.
   assign grant_en  = (state_reg == S_IDLE) && (pend_vec != 2'b00);
   assign grant_sel = (pend_vec == 2'b11) ? ~last_grant_reg : pend_vec[1];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_req
         logic          pend_reg;
         logic [AW-1:0] paddr_reg;
         logic [AW-1:0] tag_reg;
         logic          tag_v_reg;
         logic          ovr_reg;
         logic [7:0]    data_reg;
         logic          hit;
         logic          miss;
         logic          ovr_set;

         assign grant[gi]   = grant_en && (grant_sel == 1'(gi));
         assign ack_sel[gi] = (state_reg == S_REQ) && mem_ack && (last_grant_reg == 1'(gi));
         assign hit         = tag_v_reg && (addr_in[gi] == tag_reg);
         assign miss        = roe[gi] && !hit;
         // A slot that is granted on the same edge is served, so it is not overwritten.
         assign ovr_set     = miss && pend_reg && !grant[gi] && (paddr_reg != addr_in[gi]);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pend_reg  <= 1'b0;
               paddr_reg <= '0;
               tag_reg   <= '0;
               tag_v_reg <= 1'b0;
               ovr_reg   <= 1'b0;
               data_reg  <= 8'd0;
            end else begin
               if (miss) begin
                  pend_reg  <= 1'b1;
                  paddr_reg <= addr_in[gi];
               end else if (grant[gi]) begin
                  pend_reg  <= 1'b0;
               end
               if (grant[gi]) begin
                  tag_reg   <= paddr_reg;
                  tag_v_reg <= 1'b1;
               end
               if (ovr_set)
                  ovr_reg <= 1'b1;
               else if (ovr_clr)
                  ovr_reg <= 1'b0;
               if (ack_sel[gi])
                  data_reg <= mem_din;
            end
         end

         assign pend_vec[gi]  = pend_reg;
         assign paddr_vec[gi] = paddr_reg;
         assign data_vec[gi]  = data_reg;
         assign ovr_vec[gi]   = ovr_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_IDLE;
         mem_req_reg    <= 1'b0;
         mem_addr_reg   <= '0;
         busy_reg       <= 1'b0;
         last_grant_reg <= 1'b1;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (grant_en) begin
                  mem_req_reg    <= 1'b1;
                  mem_addr_reg   <= paddr_vec[grant_sel];
                  busy_reg       <= 1'b1;
                  last_grant_reg <= grant_sel;
                  state_reg      <= S_REQ;
               end
            end
            S_REQ: begin
               if (mem_ack) begin
                  mem_req_reg <= 1'b0;
                  busy_reg    <= 1'b0;
                  state_reg   <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign mem_req  = mem_req_reg;
   assign mem_addr = mem_addr_reg;
   assign busy     = busy_reg;
   assign a_data   = data_vec[0];
   assign b_data   = data_vec[1];
   assign ovr_a    = ovr_vec[0];
   assign ovr_b    = ovr_vec[1];

endmodule

// File: tb/tb_jt10_adpcm_romarb.sv
// Scoreboard bench for jt10_adpcm_romarb: expected fetches are queued as strobes are driven.
// A memory responder pops each fetch, checks its address, and checks the returned byte after the ack.
module tb_jt10_adpcm_romarb;
   localparam int AW = 24;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          a_roe_n = 1'b1;
   logic [AW-1:0] a_addr = '0;
   logic [7:0]    a_data;
   logic          b_roe_n = 1'b1;
   logic [AW-1:0] b_addr = '0;
   logic [7:0]    b_data;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_ack = 1'b0;
   logic [7:0]    mem_din = 8'd0;
   logic          busy;
   logic          ovr_a;
   logic          ovr_b;
   logic          ovr_clr = 1'b0;

   jt10_adpcm_romarb #(.AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_roe_n(a_roe_n), .a_addr(a_addr), .a_data(a_data),
      .b_roe_n(b_roe_n), .b_addr(b_addr), .b_data(b_data),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_din(mem_din),
      .busy(busy), .ovr_a(ovr_a), .ovr_b(ovr_b), .ovr_clr(ovr_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            who;   // 0 = A, 1 = B
      logic [AW-1:0] addr;
   } fetch_t;

   fetch_t sb[$];
   fetch_t cur;
   int     n_vec = 0;
   int     n_bad = 0;
   int     fetches = 0;
   int     req_cnt = 0;
   int     ack_dly = 3;
   bit     ack_hold = 1'b0;
   bit     data_chk = 1'b0;

   function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5B;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   // Memory model and scoreboard consumer
   always @(negedge clk) begin
      mem_ack = 1'b0;
      if (data_chk) begin
         data_chk = 1'b0;
         if (cur.who) check_eq("b_data", 32'(b_data), 32'(mem_byte(cur.addr)));
         else         check_eq("a_data", 32'(a_data), 32'(mem_byte(cur.addr)));
         check_eq("req_drop", 32'(mem_req), 32'd0);
      end
      if (!rst_n) begin
         req_cnt = 0;
      end else if (mem_req) begin
         if (req_cnt == 0) begin
            fetches++;
            if (sb.size() == 0) begin
               check_eq("unexpected_fetch", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
               cur = sb.pop_front();
               check_eq("mem_addr", 32'(mem_addr), 32'(cur.addr));
            end
         end
         req_cnt++;
         if (req_cnt == ack_dly && !ack_hold) begin
            mem_ack  = 1'b1;
            mem_din  = mem_byte(mem_addr);
            data_chk = 1'b1;
         end
      end else begin
         req_cnt = 0;
      end
   end

   task automatic strobe(input bit a_en, input logic [AW-1:0] aa,
                         input bit b_en, input logic [AW-1:0] ba);
      @(negedge clk);
      a_roe_n = ~a_en; a_addr = aa;
      b_roe_n = ~b_en; b_addr = ba;
      @(negedge clk);
      a_roe_n = 1'b1; b_roe_n = 1'b1;
   endtask

   task automatic push(input bit who, input logic [AW-1:0] addr);
      fetch_t f;
      f.who = who; f.addr = addr;
      sb.push_back(f);
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         #2;
         if (sb.size() == 0 && !mem_req && !data_chk) done = 1'b1;
      end
      if (!done) check_eq("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   int f0;
   bit seen;

   initial begin
      repeat (2) @(negedge clk);
      check_eq("rst_a_data", 32'(a_data), 32'd0);
      check_eq("rst_b_data", 32'(b_data), 32'd0);
      check_eq("rst_mem_req", 32'(mem_req), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_ovr", 32'({ovr_a, ovr_b}), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // Single B fetch
      push(1'b1, 24'h000100);
      strobe(1'b0, '0, 1'b1, 24'h000100);
      wait_idle();
      check_eq("b_first", 32'(b_data), 32'h5A);

      // A repeat read of the held byte must not fetch
      f0 = fetches;
      strobe(1'b0, '0, 1'b1, 24'h000100);
      repeat (6) @(negedge clk);
      check_eq("hit_fetches", 32'(fetches - f0), 32'd0);
      check_eq("hit_b_data", 32'(b_data), 32'h5A);

      // Simultaneous strobes after reset: A goes first
      do_reset();
      push(1'b0, 24'h010000);
      push(1'b1, 24'h000200);
      strobe(1'b1, 24'h010000, 1'b1, 24'h000200);
      wait_idle();

      // A served last, so the next simultaneous pair grants B first
      push(1'b0, 24'h010001);
      strobe(1'b1, 24'h010001, 1'b0, '0);
      wait_idle();
      push(1'b1, 24'h000201);
      push(1'b0, 24'h010002);
      strobe(1'b1, 24'h010002, 1'b1, 24'h000201);
      wait_idle();

      // B overwritten while A is in flight
      ack_dly = 6;
      push(1'b0, 24'h020000);
      push(1'b1, 24'h000301);
      strobe(1'b1, 24'h020000, 1'b0, '0);
      strobe(1'b0, '0, 1'b1, 24'h000300);
      strobe(1'b0, '0, 1'b1, 24'h000301);
      wait_idle();
      check_eq("ovr_b_set", 32'(ovr_b), 32'd1);
      check_eq("ovr_a_clear", 32'(ovr_a), 32'd0);
      @(negedge clk); ovr_clr = 1'b1;
      @(negedge clk); ovr_clr = 1'b0;
      check_eq("ovr_b_cleared", 32'(ovr_b), 32'd0);

      // Reset while a fetch is outstanding
      ack_dly = 3;
      ack_hold = 1'b1;
      push(1'b1, 24'h000400);
      strobe(1'b0, '0, 1'b1, 24'h000400);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (mem_req) seen = 1'b1;
      end
      check_eq("req_before_rst", 32'(seen), 32'd1);
      @(negedge clk); rst_n = 1'b0;
      #1;
      check_eq("rst_mid_req", 32'(mem_req), 32'd0);
      check_eq("rst_mid_busy", 32'(busy), 32'd0);
      check_eq("rst_mid_data", 32'({a_data, b_data}), 32'd0);
      check_eq("rst_mid_ovr", 32'({ovr_a, ovr_b}), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      ack_hold = 1'b0;
      push(1'b1, 24'h000400);
      strobe(1'b0, '0, 1'b1, 24'h000400);
      wait_idle();
      check_eq("post_rst_b", 32'(b_data), 32'(mem_byte(24'h000400)));
      check_eq("sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
